// File: rtl/sd_cmd_engine.sv
// SD command-line engine: clock divider, CRC7-framed command serialiser, response capture
// with timeout/CRC checking, and a register-driven bit-bang mode for the SD pins.
module sd_cmd_engine #(
  parameter int unsigned DIV_RESET = 124,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [2:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        SD_CLK,
  input  logic        SD_CMD_in,
  output logic        SD_CMD_out,
  output logic        SD_CMD_oe,
  input  logic [3:0]  SD_DAT_in,
  output logic [3:0]  SD_DAT_out,
  output logic        SD_DAT_oe
);
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_CHECK, S_FINISH} state_e;

  // CRC7 (x^7 + x^3 + 1), register starts at zero, data MSB first
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  state_e               state_q;
  logic [DIV_WIDTH-1:0] div_q, cnt_q;
  logic [31:0]          arg_q, rdata_q;
  logic [1:0]           rtype_q;
  logic                 busy_q, done_q, tout_q, crc_err_q, ready_q;
  logic [3:0][31:0]     resp_q;
  logic [7:0]           bb_q;
  logic                 bb_en_q;
  logic                 sclk_q, cmd_out_q, cmd_oe_q;
  logic [47:0]          tx_q;
  logic [135:0]         rx_q;
  logic [7:0]           bit_q;
  logic [TO_W-1:0]      wcnt_q;
  logic [2:0]           fcnt_q;

  logic        edge_c, rise_c, fall_c, wr_c, start_c, crc_bad_c;
  logic [7:0]  rlen_c, bb_rd_c;
  logic [39:0] cmd40_c;
  logic [47:0] frame_c;
  logic [31:0] rd_c;
  logic        unused_c;

  // SD_CLK edge events: the divider counter wraps on the cycle the clock toggles
  assign edge_c  = busy_q && (cnt_q == div_q);
  assign rise_c  = edge_c && !sclk_q;
  assign fall_c  = edge_c && sclk_q;
  assign wr_c    = i_request && i_rw;
  assign start_c = wr_c && (i_address == 3'd0) && i_wdata[8] && !busy_q && !bb_en_q;
  assign rlen_c  = (rtype_q == 2'b10) ? 8'd135 : 8'd47;
  assign cmd40_c = {2'b01, i_wdata[5:0], arg_q};
  assign frame_c = {cmd40_c, crc7(cmd40_c), 1'b1};
  assign bb_rd_c = {bb_q[2] ? bb_q[7:4] : SD_DAT_in, bb_q[1] ? bb_q[3] : SD_CMD_in, bb_q[2:0]};
  assign unused_c = &{1'b0, i_wdata[31:17], rx_q[135]};

  always_comb begin
    crc_bad_c = !rx_q[0];
    if (rtype_q == 2'b01 && crc7(rx_q[47:8]) != rx_q[7:1]) crc_bad_c = 1'b1;
  end

  always_comb begin
    rd_c = '0;
    case (i_address)
      3'd0:    rd_c = {28'd0, crc_err_q, tout_q, done_q, busy_q};
      3'd1:    rd_c = arg_q;
      3'd2:    rd_c = 32'(div_q);
      3'd3:    rd_c = {15'd0, bb_en_q, 8'd0, bb_rd_c};
      default: rd_c = resp_q[i_address[1:0]];
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      div_q     <= DIV_WIDTH'(DIV_RESET);
      cnt_q     <= '0;
      arg_q     <= '0;
      rdata_q   <= '0;
      rtype_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
      crc_err_q <= 1'b0;
      ready_q   <= 1'b0;
      resp_q    <= '0;
      bb_q      <= '0;
      bb_en_q   <= 1'b0;
      sclk_q    <= 1'b0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_q     <= '0;
      wcnt_q    <= '0;
      fcnt_q    <= '0;
    end else begin
      ready_q <= i_request;
      if (i_request && !i_rw) rdata_q <= rd_c;
      if (wr_c) begin
        case (i_address)
          3'd0: if (!busy_q) rtype_q <= i_wdata[7:6];
          3'd1: if (!busy_q) arg_q <= i_wdata;
          3'd2: if (!busy_q) div_q <= i_wdata[DIV_WIDTH-1:0];
          3'd3: begin
            bb_q    <= (bb_q & ~i_wdata[15:8]) | i_wdata[7:0];
            bb_en_q <= i_wdata[16];
          end
          default: ;
        endcase
      end

      if (!busy_q) begin
        cnt_q  <= '0;
        sclk_q <= 1'b0;
      end else if (edge_c) begin
        cnt_q  <= '0;
        sclk_q <= ~sclk_q;
      end else begin
        cnt_q <= cnt_q + DIV_WIDTH'(1);
      end

      case (state_q)
        S_IDLE: if (start_c) begin
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          tout_q    <= 1'b0;
          crc_err_q <= 1'b0;
          tx_q      <= frame_c;
          cmd_out_q <= frame_c[47];
          cmd_oe_q  <= 1'b1;
          bit_q     <= '0;
          state_q   <= S_SEND;
        end
        S_SEND: if (fall_c) begin
          if (bit_q == 8'd47) begin
            cmd_oe_q  <= 1'b0;
            cmd_out_q <= 1'b1;
            wcnt_q    <= '0;
            fcnt_q    <= '0;
            state_q   <= (rtype_q == 2'b00) ? S_FINISH : S_WAIT;
          end else begin
            tx_q      <= {tx_q[46:0], 1'b0};
            cmd_out_q <= tx_q[46];
            bit_q     <= bit_q + 8'd1;
          end
        end
        S_WAIT: if (rise_c) begin
          if (!SD_CMD_in) begin
            rx_q    <= {rx_q[134:0], 1'b0};
            bit_q   <= 8'd1;
            state_q <= S_RECV;
          end else if (wcnt_q == TO_W'(TIMEOUT - 1)) begin
            tout_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            wcnt_q <= wcnt_q + TO_W'(1);
          end
        end
        S_RECV: if (rise_c) begin
          rx_q <= {rx_q[134:0], SD_CMD_in};
          if (bit_q == rlen_c) state_q <= S_CHECK;
          else bit_q <= bit_q + 8'd1;
        end
        S_CHECK: begin
          crc_err_q <= crc_bad_c;
          if (rtype_q == 2'b10) begin
            resp_q <= rx_q[127:0];
          end else begin
            resp_q[0] <= rx_q[39:8];
            resp_q[1] <= {24'd0, rx_q[47:40]};
          end
          fcnt_q  <= '0;
          state_q <= S_FINISH;
        end
        S_FINISH: if (fall_c) begin
          if (fcnt_q == 3'd7) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            fcnt_q <= fcnt_q + 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bit-bang mode hands the pins straight to the BITBANG register
  assign SD_CLK     = bb_en_q ? bb_q[0] : sclk_q;
  assign SD_CMD_out = bb_en_q ? bb_q[3] : cmd_out_q;
  assign SD_CMD_oe  = bb_en_q ? bb_q[1] : cmd_oe_q;
  assign SD_DAT_out = bb_en_q ? bb_q[7:4] : 4'h0;
  assign SD_DAT_oe  = bb_en_q & bb_q[2];
  assign o_rdata    = rdata_q;
  assign o_ready    = ready_q;

endmodule
